// File: rtl/alu_mdu.sv
// alu_mdu: handshaked multi-cycle ALU + M-extension execute unit; define ALU_MDU_FAST_MUL_EN for a single-cycle multiplier
module alu_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic            out_busy
);
  localparam int SHW = $clog2(XLEN);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_res, r_hi, r_lo, r_d, w_alu, w_nhi, w_nlo, w_sub, w_fix;
  logic [2*XLEN-1:0] w_p, w_pn;
  logic [XLEN:0] w_msum, w_sh;
  logic [SHW-1:0] r_cnt;
  logic [4:0] r_op;
  logic r_nq, r_nr, r_div;
  logic w_acc, w_iter, w_sa, w_sb, w_lt, w_ltu, w_eq, w_ge, w_last;
`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fprod;
`endif
  // Handshake, operand signedness and comparison flags
  always_comb begin
    w_acc = in_valid & in_ready;
    w_sa = in_src1[XLEN-1] & (in_op inside {5'd17, 5'd18, 5'd19, 5'd21, 5'd23});
    w_sb = in_src2[XLEN-1] & (in_op inside {5'd17, 5'd18, 5'd21, 5'd23});
    w_lt = $signed(in_src1) < $signed(in_src2);
    w_ltu = in_src1 < in_src2;
    w_eq = in_src1 == in_src2;
`ifdef ALU_MDU_FAST_MUL_EN
    w_fprod = {{XLEN{w_sa}}, in_src1} * {{XLEN{w_sb}}, in_src2};
    w_iter = in_op inside {[5'd21:5'd24]};
`else
    w_iter = in_op inside {[5'd17:5'd24]};
`endif
  end
  // Single-cycle result for ALU ops; illegal and iterative ops yield 0 here
  always_comb begin
    w_alu = '0;
    case (in_op)
      5'd0:  w_alu = in_src1 + in_src2;
      5'd1:  w_alu = in_src1 - in_src2;
      5'd2:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd3:  w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd4:  w_alu = in_src1 & in_src2;
      5'd5:  w_alu = in_src1 ^ in_src2;
      5'd6:  w_alu = in_src1 | in_src2;
      5'd7:  w_alu = in_src1 << in_src2[SHW-1:0];
      5'd8:  w_alu = in_src1 >> in_src2[SHW-1:0];
      5'd9:  w_alu = $signed(in_src1) >>> in_src2[SHW-1:0];
      5'd10: w_alu = XLEN'($signed(in_src2[31:12])) << 12;
      5'd11: w_alu = {{(XLEN-1){1'b0}}, w_eq};
      5'd12: w_alu = {{(XLEN-1){1'b0}}, ~w_eq};
      5'd13: w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd14: w_alu = {{(XLEN-1){1'b0}}, ~w_lt};
      5'd15: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd16: w_alu = {{(XLEN-1){1'b0}}, ~w_ltu};
`ifdef ALU_MDU_FAST_MUL_EN
      5'd17: w_alu = w_fprod[XLEN-1:0];
      5'd18, 5'd19, 5'd20: w_alu = w_fprod[2*XLEN-1:XLEN];
`endif
      default: w_alu = '0;
    endcase
  end
  // One shift-add or restoring-divide step on magnitudes; sign fix-up folded into the last step
  always_comb begin
    w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
    w_sh = {r_hi, r_lo[XLEN-1]};
    w_ge = w_sh >= {1'b0, r_d};
    w_sub = w_sh[XLEN-1:0] - r_d;
    w_nhi = r_div ? (w_ge ? w_sub : w_sh[XLEN-1:0]) : w_msum[XLEN:1];
    w_nlo = r_div ? {r_lo[XLEN-2:0], w_ge} : {w_msum[0], r_lo[XLEN-1:1]};
    w_p = {w_nhi, w_nlo};
    w_pn = r_nq ? -w_p : w_p;
    w_fix = r_op == 5'd17 ? w_pn[XLEN-1:0] : r_op <= 5'd20 ? w_pn[2*XLEN-1:XLEN] :
            r_op <= 5'd22 ? (r_nq ? -w_nlo : w_nlo) : (r_nr ? -w_nhi : w_nhi);
    w_last = r_cnt == SHW'(XLEN - 1);
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // Next-state: ALU ops finish immediately, mul/div iterate XLEN steps, results wait for out_ready
  always_comb begin
    w_next = r_state == S_IDLE ? (w_acc ? (w_iter ? S_BUSY : S_DONE) : S_IDLE) :
             r_state == S_BUSY ? (w_last ? S_DONE : S_BUSY) : (out_ready ? S_IDLE : S_DONE);
  end
  // Outputs decoded from state; result masked to 0 while not valid
  always_comb begin
    in_ready = (r_state == S_IDLE) & ~rst;
    out_valid = r_state == S_DONE;
    out_busy = r_state == S_BUSY;
    out_res = r_state == S_DONE ? r_res : '0;
  end
  // Latch operands on accept; a zero divisor keeps the quotient unnegated so it stays all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_res <= w_alu;
      r_cnt <= '0;
      r_op <= in_op;
      r_div <= in_op >= 5'd21;
      r_nq <= (w_sa ^ w_sb) & |in_src2;
      r_nr <= w_sa;
      r_hi <= '0;
      r_lo <= w_sa ? -in_src1 : in_src1;
      r_d <= w_sb ? -in_src2 : in_src2;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi <= w_nhi;
      r_lo <= w_nlo;
      if (w_last) r_res <= w_fix;
    end
  end
endmodule
